sprite_blitter: RTL

Writes one 24x45 sprite from the sprite ROM into the frame buffer at a requested screen position, one pixel per clock. It is the write-side counterpart of the per-pixel sprite read path: the draw path reads encoded 5-bit pixels out by DrawX/DrawY, and this block places encoded pixels into frame-buffer memory. Index 0 is transparent and is never written. Pixels beyond the right or bottom screen edge are clipped. An optional horizontal flip produces left-facing sprites from right-facing ROM data.

---
 rtl/sprite_blitter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sprite_blitter.sv
// Sprite-to-frame-buffer blitter: streams one SPRITE_W x SPRITE_H sprite from a
// synchronous ROM into the frame buffer, one pixel slot per clock, with clipping.
module sprite_blitter #(
  parameter int unsigned SPRITE_W = 24,
  parameter int unsigned SPRITE_H = 45,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned PIX_W    = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [9:0]       spriteX,
  input  logic [9:0]       spriteY,
  input  logic             flip,
  output logic             busy,
  output logic             done,
  output logic [10:0]      rom_addr,
  input  logic [PIX_W-1:0] rom_data,
  output logic             fb_we,
  output logic [18:0]      fb_addr,
  output logic [PIX_W-1:0] fb_data
);

  localparam int unsigned XW = $clog2(SPRITE_W);
  localparam int unsigned YW = $clog2(SPRITE_H);
  localparam logic [XW-1:0] SX_LAST = XW'(SPRITE_W - 1);
  localparam logic [YW-1:0] SY_LAST = YW'(SPRITE_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     sx_q, sx_d;
  logic [YW-1:0]     sy_q, sy_d;
  logic              flip_q, flip_d;
  logic [9:0]        spx_q, spx_d;
  logic [9:0]        spy_q, spy_d;
  logic              drain_q, drain_d;
  logic [XW-1:0]     col_d;
  logic [10:0]       rom_addr_q, rom_addr_d;

  logic              v1_q;
  logic [10:0]       x1_q, y1_q;
  logic              we_d;
  logic [18:0]       addr_d;
  logic              fb_we_q;
  logic [18:0]       fb_addr_q;
  logic [PIX_W-1:0]  fb_data_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      sx_q       <= '0;
      sy_q       <= '0;
      flip_q     <= 1'b0;
      spx_q      <= '0;
      spy_q      <= '0;
      drain_q    <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      flip_q     <= flip_d;
      spx_q      <= spx_d;
      spy_q      <= spy_d;
      drain_q    <= drain_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    flip_d  = flip_q;
    spx_d   = spx_q;
    spy_d   = spy_q;
    drain_d = drain_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          spx_d   = spriteX;
          spy_d   = spriteY;
          flip_d  = flip;
          sx_d    = '0;
          sy_d    = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (sx_q == SX_LAST) begin
          sx_d = '0;
          if (sy_q == SY_LAST) begin
            sy_d    = '0;
            drain_d = 1'b0;
            state_d = S_DRAIN;
          end else begin
            sy_d = sy_q + 1'b1;
          end
        end else begin
          sx_d = sx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q) state_d = S_DONE;
        else         drain_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Address is registered from the next counter values so that rom_addr
    // presents the pixel the counters will hold in the following cycle.
    col_d      = flip_d ? (SX_LAST - sx_d) : sx_d;
    rom_addr_d = 11'(sy_d) * 11'(SPRITE_W) + 11'(col_d);
  end

  // Stage 1 carries the destination alongside the ROM read in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v1_q      <= 1'b0;
      x1_q      <= '0;
      y1_q      <= '0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      v1_q      <= (state_q == S_RUN);
      x1_q      <= {1'b0, spx_q} + 11'(sx_q);
      y1_q      <= {1'b0, spy_q} + 11'(sy_q);
      fb_we_q   <= we_d;
      fb_addr_q <= we_d ? addr_d : '0;
      fb_data_q <= rom_data;
    end
  end

  always_comb begin
    we_d   = v1_q && (x1_q < 11'(SCREEN_W)) && (y1_q < 11'(SCREEN_H)) && (rom_data != '0);
    addr_d = 19'(y1_q) * 19'(SCREEN_W) + 19'(x1_q);
  end

  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign rom_addr = rom_addr_q;
  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_data  = fb_data_q;

endmodule
